// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: request bundle, FSM states, bus widths.
package dmem_pkg;
   localparam int DMEM_BE_W = 4;
   localparam int DMEM_DW   = 32;
   localparam int DMEM_AW   = 32;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

   typedef struct packed {
      logic                 we;
      logic [DMEM_AW-1:0]   addr;
      logic [DMEM_DW-1:0]   wdata;
      logic [DMEM_BE_W-1:0] be;
   } dmem_req_t;
endpackage

// File: rtl/dmem_if.sv
// Data-memory port: valid/ready request channel and valid/ready response channel.
interface dmem_if;
   import dmem_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [DMEM_AW-1:0]   req_addr;
   logic [DMEM_DW-1:0]   req_wdata;
   logic [DMEM_BE_W-1:0] req_be;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [DMEM_DW-1:0]   resp_rdata;
   logic                 resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_array.sv
// Single-port word array with byte-enable write and a registered read that holds
// its value whenever the port is not enabled. Contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH = 1024,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [DMEM_BE_W-1:0] be,
   input  logic [IW-1:0]        idx,
   input  logic [DMEM_DW-1:0]   wdata,
   output logic [DMEM_DW-1:0]   rdata
);

   logic [DMEM_DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < DMEM_BE_W; i++) begin
               if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding data-memory responder in front of dmem_array.
//   state | meaning
//   IDLE  | ready for a request (req_ready=1)
//   WAIT  | request accepted, latency counter running down
//   RESP  | response presented, held until resp_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);

   localparam int         IW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   dmem_state_t        state;
   logic [3:0]         cnt;
   logic               resp_valid;
   logic               resp_err;
   logic               rdata_en;
   logic               lat_we;
   logic               lat_err;
   dmem_req_t          req;
   logic               req_err;
   logic               accept;
   logic [DMEM_DW-1:0] rd_word;

   assign req     = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
   assign req_err = (req.addr[1:0] != 2'b00) || (req.addr[31:2] >= 30'(DEPTH));
   assign accept  = bus.req_valid && (state == IDLE);

   // Store commits and load reads both happen on the accept edge; the array's
   // read register then holds the word until the next accepted request.
   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .en    (accept && !req_err),
      .we    (req.we),
      .be    (req.be),
      .idx   (req.addr[IW+1:2]),
      .wdata (req.wdata),
      .rdata (rd_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         rdata_en   <= 1'b0;
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we  <= req.we;
                  lat_err <= req_err;
                  if (LATENCY == 1) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= req_err;
                     rdata_en   <= !req.we && !req_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state      <= RESP;
                  cnt        <= '0;
                  resp_valid <= 1'b1;
                  resp_err   <= lat_err;
                  rdata_en   <= !lat_we && !lat_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  rdata_en   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = resp_valid;
   assign bus.resp_err   = resp_err;
   assign bus.resp_rdata = rdata_en ? rd_word : '0;

endmodule
